seq_calculator: RTL and testbench
=================================

// Module: seq_calculator
// PURPOSE
//  Parametrised, handshaked successor to the 4-bit combinational calculator.
//  Accepts one operand pair and an opcode per transaction and computes
//  add, sub, mul or div on WIDTH-bit unsigned operands.
//  Produces a registered 2*WIDTH-bit result. Division is iterative (restoring).
//  Sits between operand source and result sink on valid/ready streams.
// PARAMETERS
//  WIDTH  8  operand width in bits (>=2); result is 2*WIDTH bits
// PORTS
//  clk          in   1          rising-edge clock
//  rst          in   1          asynchronous reset, active-high
//  in_valid     in   1          operand/opcode valid
//  in_ready     out  1          block can accept a transaction
//  dat_a_in     in   WIDTH      operand A (unsigned)
//  dat_b_in     in   WIDTH      operand B (unsigned)
//  function_in  in   2          00 add, 01 sub, 10 mul, 11 div
//  out_valid    out  1          result valid
//  out_ready    in   1          sink accepts result
//  out          out  2*WIDTH    result
//  div_by_zero  out  1          valid with out; set only for div with B==0
//  busy         out  1          high in CALC state
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, out=0, out_valid=0,
//    div_by_zero=0, busy=0, internal operand/iteration regs cleared.
//    In-flight operation discarded, no result emitted.
//  - FSM IDLE -> CALC -> DONE -> IDLE.
//    IDLE: in_ready=1. in_valid&in_ready at edge E0 latches A, B and opcode,
//      then goes to CALC. Inputs are ignored after E0.
//    CALC: busy=1, in_ready=0.
//      add/sub/mul, and div with B==0: result registered at E1, then DONE.
//      div with B!=0: one quotient bit per cycle, MSB first, WIDTH cycles.
//      Result registered at E_WIDTH, then DONE.
//    DONE: out_valid=1, out and div_by_zero stable. in_ready=0.
//      out_valid&out_ready at an edge -> IDLE, out_valid=0. out holds its
//      last value; div_by_zero clears.
//  - Max throughput: one transaction per (latency+2) cycles. No overlap of
//    accept and result handshake.
//  - Arithmetic (A, B zero-extended to 2*WIDTH):
//    add: A+B; carry lands in bit WIDTH, upper bits 0.
//    sub: (A-B) mod 2^(2*WIDTH), i.e. sign-extended difference.
//    mul: full 2*WIDTH product.
//    div: out[WIDTH-1:0]=A/B, out[2*WIDTH-1:WIDTH]=A%B.
//    div B==0: quotient all ones, remainder=A, div_by_zero=1.
//  - out_ready held low in DONE: stays in DONE indefinitely, outputs frozen.
//  - out_ready high outside DONE: no effect.
//  - in_valid in CALC/DONE: not accepted; the source must hold it until
//    in_ready.
// TESTING  (WIDTH=8)
//  - add 200+100, out_ready=1 -> out=16'h012C, out_valid 1 cycle after
//    accept edge, div_by_zero=0.
//  - sub 5-7 -> out=16'hFFFE. mul 255*255 -> out=16'hFE01, latency 1.
//  - div 200/7 -> out=16'h041C (rem 4, quo 28). busy high 8 cycles;
//    out_valid after 8th CALC edge.
//  - div 13/0 -> out=16'h0DFF, div_by_zero=1, latency 1.
//  - mul 3*4 with out_ready low 5 cycles -> out=16'h000C held, in_ready=0
//    throughout. Then IDLE 1 cycle after out_ready rises.
//  - rst pulsed mid-div (cycle 4 of CALC) -> all outputs 0, in_ready=1 after
//    release. Next add 1+1 -> out=16'h0002.

Source files
------------

// File: rtl/seq_calculator_if.sv
// Purpose : valid/ready stream bundle for seq_calculator. Operands and opcode
//           come in on one stream and the result leaves on the other.
// Signals : in_valid/in_ready, dat_a_in, dat_b_in, function_in  (operand side)
//           out_valid/out_ready, out, div_by_zero, busy           (result side)
// Modports: master = operand source / result sink, slave = calculator.
interface seq_calculator_if #(
  parameter int WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   dat_a_in;
  logic [WIDTH-1:0]   dat_b_in;
  logic [1:0]         function_in;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] out;
  logic               div_by_zero;
  logic               busy;

  modport master (
    output in_valid, dat_a_in, dat_b_in, function_in, out_ready,
    input  in_ready, out_valid, out, div_by_zero, busy
  );

  modport slave (
    input  in_valid, dat_a_in, dat_b_in, function_in, out_ready,
    output in_ready, out_valid, out, div_by_zero, busy
  );
endinterface

// File: rtl/seq_calculator.sv
// Purpose : handshaked unsigned calculator. Takes one operand pair plus an
//           opcode (00 add, 01 sub, 10 mul, 11 div) and returns a registered
//           2*WIDTH-bit result. Division is restoring, one quotient bit per
//           cycle, MSB first; the result carries the remainder in the upper
//           half and the quotient in the lower half.
// Ports   : clk  - rising-edge clock
//           rst  - asynchronous reset, active high
//           bus  - seq_calculator_if.slave (operand and result streams, busy)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | in_ready high, waiting for an operand pair
// CALC  | busy high; one cycle for add/sub/mul/div-by-zero, WIDTH for div
// DONE  | out_valid high, result frozen until out_ready
module seq_calculator #(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  seq_calculator_if.slave bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   a_reg;
  logic [WIDTH-1:0]   b_reg;
  logic [1:0]         op_reg;
  logic [WIDTH-1:0]   rem;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] out_reg;
  logic               out_valid_reg;
  logic               dz_reg;
  logic               busy_reg;
  logic               in_ready_reg;

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] alu_res;
  logic [WIDTH:0]     rem_shift;
  logic [WIDTH:0]     rem_diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_next;
  logic [WIDTH-1:0]   quo_next;
  logic               iter_div;

  // a_reg doubles as the dividend shift register: its MSB feeds the partial
  // remainder and the new quotient bit enters at the LSB, so after WIDTH
  // steps it holds the quotient.
  always_comb begin
    a_ext     = {{WIDTH{1'b0}}, a_reg};
    b_ext     = {{WIDTH{1'b0}}, b_reg};
    rem_shift = {rem, a_reg[WIDTH-1]};
    rem_diff  = rem_shift - {1'b0, b_reg};
    q_bit     = ~rem_diff[WIDTH];          // no borrow -> divisor fits
    rem_next  = q_bit ? rem_diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
    quo_next  = {a_reg[WIDTH-2:0], q_bit};
    iter_div  = (op_reg == 2'b11) && (b_reg != '0);
    case (op_reg)
      2'b00:   alu_res = a_ext + b_ext;
      2'b01:   alu_res = a_ext - b_ext;
      2'b10:   alu_res = a_ext * b_ext;
      // only reached for divide by zero: remainder = A, quotient all ones
      default: alu_res = {a_reg, {WIDTH{1'b1}}};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= '0;
      rem           <= '0;
      cnt           <= '0;
      out_reg       <= '0;
      out_valid_reg <= 1'b0;
      dz_reg        <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid && in_ready_reg) begin
            a_reg        <= bus.dat_a_in;
            b_reg        <= bus.dat_b_in;
            op_reg       <= bus.function_in;
            rem          <= '0;
            cnt          <= CNT_W'(WIDTH - 1);
            state        <= CALC;
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
          end
        end
        CALC: begin
          if (iter_div) begin
            a_reg <= quo_next;
            rem   <= rem_next;
            if (cnt == '0) begin
              out_reg       <= {rem_next, quo_next};
              dz_reg        <= 1'b0;
              state         <= DONE;
              busy_reg      <= 1'b0;
              out_valid_reg <= 1'b1;
            end else begin
              cnt <= cnt - 1'b1;
            end
          end else begin
            out_reg       <= alu_res;
            dz_reg        <= (op_reg == 2'b11);
            state         <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (bus.out_ready) begin
            state         <= IDLE;
            out_valid_reg <= 1'b0;
            dz_reg        <= 1'b0;
            in_ready_reg  <= 1'b1;
          end
        end
        default: begin
          state         <= IDLE;
          out_valid_reg <= 1'b0;
          dz_reg        <= 1'b0;
          busy_reg      <= 1'b0;
          in_ready_reg  <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready    = in_ready_reg;
  assign bus.out_valid   = out_valid_reg;
  assign bus.out         = out_reg;
  assign bus.div_by_zero = dz_reg;
  assign bus.busy        = busy_reg;

endmodule

// File: tb/tb_seq_calculator.sv
module tb_seq_calculator;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;
  logic [16:0] sb[$];   // {div_by_zero, out}

  seq_calculator_if #(.WIDTH(8)) bus ();

  seq_calculator #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic [1:0] op);
    logic [15:0] ae;
    logic [15:0] be;
    logic [7:0]  q;
    logic [7:0]  r;
    ae = {8'h00, a};
    be = {8'h00, b};
    case (op)
      2'b00: return {1'b0, ae + be};
      2'b01: return {1'b0, ae - be};
      2'b10: return {1'b0, ae * be};
      default: begin
        if (b == 8'h00) return {1'b1, a, 8'hFF};
        q = a / b;
        r = a % b;
        return {1'b0, r, q};
      end
    endcase
  endfunction

  task automatic do_txn(input logic [7:0] a, input logic [7:0] b, input logic [1:0] op,
                        input int hold, input string name);
    int lat;
    int bcnt;
    int exp_lat;
    logic [16:0] e;
    logic [15:0] held;
    exp_lat = (op == 2'b11 && b != 8'h00) ? 8 : 1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s in_ready_before: got %b expected 1", name, bus.in_ready);
    end
    bus.dat_a_in    = a;
    bus.dat_b_in    = b;
    bus.function_in = op;
    bus.in_valid    = 1'b1;
    bus.out_ready   = (hold == 0);
    sb.push_back(model(a, b, op));
    @(negedge clk);
    bus.in_valid    = 1'b0;
    bus.dat_a_in    = ~a;
    bus.dat_b_in    = ~b;
    bus.function_in = ~op;
    lat  = 0;
    bcnt = 0;
    while (bus.out_valid !== 1'b1 && lat < 50) begin
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
      lat++;
    end
    if (lat >= 50) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: out_valid not seen within %0d cycles", name, lat);
      void'(sb.pop_front());
      bus.out_ready = 1'b0;
      return;
    end
    e = sb.pop_front();
    checks++;
    if (bus.out !== e[15:0]) begin
      errors++;
      $display("FAIL %s out: got %h expected %h", name, bus.out, e[15:0]);
    end
    checks++;
    if (bus.div_by_zero !== e[16]) begin
      errors++;
      $display("FAIL %s div_by_zero: got %b expected %b", name, bus.div_by_zero, e[16]);
    end
    checks++;
    if (lat != exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (bcnt != exp_lat) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d expected %0d", name, bcnt, exp_lat);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s done_flags: got busy=%b in_ready=%b expected busy=0 in_ready=0",
               name, bus.busy, bus.in_ready);
    end
    held = bus.out;
    repeat (hold) begin
      @(negedge clk);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out !== held || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL %s hold: got valid=%b out=%h in_ready=%b expected valid=1 out=%h in_ready=0",
                 name, bus.out_valid, bus.out, bus.in_ready, held);
      end
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.div_by_zero !== 1'b0 ||
        bus.out !== held) begin
      errors++;
      $display("FAIL %s release: got valid=%b in_ready=%b dz=%b out=%h expected 0 1 0 %h",
               name, bus.out_valid, bus.in_ready, bus.div_by_zero, bus.out, held);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0 || bus.div_by_zero !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got out=%h valid=%b dz=%b busy=%b expected all 0",
               bus.out, bus.out_valid, bus.div_by_zero, bus.busy);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add();
    do_txn(8'd200, 8'd100, 2'b00, 0, "add_200_100");
    do_txn(8'd255, 8'd255, 2'b00, 0, "add_255_255");
  endtask

  task automatic test_sub();
    do_txn(8'd5, 8'd7, 2'b01, 0, "sub_5_7");
    do_txn(8'd7, 8'd5, 2'b01, 0, "sub_7_5");
  endtask

  task automatic test_mul();
    do_txn(8'd255, 8'd255, 2'b10, 0, "mul_255_255");
  endtask

  task automatic test_div();
    do_txn(8'd200, 8'd7, 2'b11, 0, "div_200_7");
    do_txn(8'd255, 8'd1, 2'b11, 0, "div_255_1");
    do_txn(8'd5, 8'd10, 2'b11, 0, "div_5_10");
  endtask

  task automatic test_div_zero();
    do_txn(8'd13, 8'd0, 2'b11, 0, "div_13_0");
  endtask

  task automatic test_backpressure();
    do_txn(8'd3, 8'd4, 2'b10, 5, "mul_3_4_hold");
  endtask

  task automatic test_reset_mid_div();
    bus.dat_a_in    = 8'd200;
    bus.dat_b_in    = 8'd7;
    bus.function_in = 2'b11;
    bus.in_valid    = 1'b1;
    bus.out_ready   = 1'b1;
    sb.push_back(model(8'd200, 8'd7, 2'b11));
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    sb.delete();
    #1;
    checks++;
    if (bus.out !== 16'h0000 || bus.out_valid !== 1'b0 || bus.div_by_zero !== 1'b0 ||
        bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_div_outputs: got out=%h valid=%b dz=%b busy=%b expected all 0",
               bus.out, bus.out_valid, bus.div_by_zero, bus.busy);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL rst_mid_div_idle: got in_ready=%b valid=%b expected 1 0",
                 bus.in_ready, bus.out_valid);
      end
    end
    bus.out_ready = 1'b0;
    do_txn(8'd1, 8'd1, 2'b00, 0, "add_1_1_after_rst");
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    for (int i = 0; i < 20; i++) begin
      a  = 8'($urandom_range(0, 255));
      b  = (i % 5 == 4) ? 8'h00 : 8'($urandom_range(0, 255));
      op = 2'($urandom_range(0, 3));
      do_txn(a, b, op, i % 3, "b2b");
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.in_valid    = 1'b0;
    bus.dat_a_in    = '0;
    bus.dat_b_in    = '0;
    bus.function_in = '0;
    bus.out_ready   = 1'b0;
    test_reset();
    test_add();
    test_sub();
    test_mul();
    test_div();
    test_div_zero();
    test_backpressure();
    test_reset_mid_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
